weakbus_arbiter: RTL and testbench

- Shares one 32-bit memory bus between NMASTERS requesters, e.g. the weakcore instruction/data port plus a DMA or debug master.
- Uses the same req/ack bus protocol as the core on both sides, so it drops in between the core and the memory/peripheral fabric.
- Round-robin arbitration: a grant is held until the slave acks, then released.
- One transfer per grant; no bursts, no pipelining.

---
 rtl/weakbus_defs.sv | 20 ++
 rtl/weakbus_rr_pick.sv | 36 +++
 rtl/weakbus_arbiter.sv | 155 +++++++++++++++
 tb/tb_weakbus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weakbus_defs.sv
`default_nettype none
// ============================================================================
// Package  : weakbus_defs
// Summary  : Shared bus widths, arbiter state encoding and timeout poison word.
// Revision : 1.0
// ============================================================================
package weakbus_defs;

    localparam int c_data_w = 32;
    localparam int c_mask_w = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [c_data_w-1:0] c_poison = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/weakbus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : weakbus_rr_pick
// Summary  : Combinational round-robin picker; scans from i_last+1 with wrap.
// Revision : 1.0
// ============================================================================
module weakbus_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_winner,
    output logic             o_valid
);

    logic w_found;

    // Offset k walks the ring starting just after the last-served index.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (((int'(i_last) + 1 + k) % N) == i)) begin
                    o_winner[i] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/weakbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : weakbus_arbiter
// Summary  : Round-robin req/ack arbiter for one 32-bit bus; optional watchdog
//            enabled by WEAKBUS_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module weakbus_arbiter
    import weakbus_defs::*;
#(
    parameter int NMASTERS = 2,
    parameter int TMO_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NMASTERS-1:0]          m_req,
    input  logic [c_data_w*NMASTERS-1:0] m_addr,
    input  logic [c_data_w*NMASTERS-1:0] m_out,
    input  logic [NMASTERS-1:0]          m_wr,
    input  logic [c_mask_w*NMASTERS-1:0] m_wr_mask,
    output logic [c_data_w-1:0]          m_in,
    output logic [NMASTERS-1:0]          m_ack,
    output logic                         s_req,
    output logic [c_data_w-1:0]          s_addr,
    output logic [c_data_w-1:0]          s_out,
    output logic                         s_wr,
    output logic [c_mask_w-1:0]          s_wr_mask,
    input  logic [c_data_w-1:0]          s_in,
    input  logic                         s_ack,
    output logic [NMASTERS-1:0]          grant,
    output logic                         err
);

    localparam int                 c_idx_w    = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NMASTERS - 1);

    state_t                r_state;
    logic [NMASTERS-1:0]   r_grant;
    logic [c_idx_w-1:0]    r_last;

    logic [NMASTERS-1:0]   w_pick;
    logic                  w_pick_valid;
    logic                  w_busy;
    logic                  w_req_g;
    logic                  w_done;
    logic                  w_tmo_fire;
    logic [c_idx_w-1:0]    w_gidx;
    logic [c_data_w-1:0]   w_addr;
    logic [c_data_w-1:0]   w_out;
    logic [c_mask_w-1:0]   w_mask;
    logic                  w_wr;

    weakbus_rr_pick #(
        .N     (NMASTERS),
        .IDX_W (c_idx_w)
    ) u_pick (
        .i_req    (m_req),
        .i_last   (r_last),
        .o_winner (w_pick),
        .o_valid  (w_pick_valid)
    );

    assign w_busy  = (r_state == ST_BUSY);
    assign w_req_g = |(m_req & r_grant);
    assign w_done  = s_ack | w_tmo_fire;

    // One-hot grant selects the owner's slice; an empty grant yields zeros.
    always_comb begin
        w_gidx = '0;
        w_addr = '0;
        w_out  = '0;
        w_mask = '0;
        w_wr   = 1'b0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (r_grant[i]) begin
                w_gidx = c_idx_w'(i);
                w_addr = m_addr[i*c_data_w +: c_data_w];
                w_out  = m_out[i*c_data_w +: c_data_w];
                w_mask = m_wr_mask[i*c_mask_w +: c_mask_w];
                w_wr   = m_wr[i];
            end
        end
    end

    assign s_req     = w_busy & w_req_g;
    assign s_addr    = w_busy ? w_addr : '0;
    assign s_out     = w_busy ? w_out  : '0;
    assign s_wr      = w_busy & w_wr;
    assign s_wr_mask = w_busy ? w_mask : '0;
    assign m_ack     = w_busy ? (r_grant & {NMASTERS{w_done}}) : '0;
    assign m_in      = w_tmo_fire ? c_poison : s_in;
    assign grant     = r_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= c_last_rst;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_last  <= w_gidx;
                    end else if (!w_req_g) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef WEAKBUS_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Counter idles at zero so it starts from zero on every BUSY entry.
    assign w_tmo_fire = w_busy & w_req_g & ~s_ack & (&r_tmo);
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_busy && !s_ack && !w_tmo_fire) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
            if (w_tmo_fire) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_fire = 1'b0;
    // Constant false; keeps TMO_W referenced when the watchdog is absent.
    assign err        = (TMO_W < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_weakbus_arbiter.sv
`default_nettype none
// Self-checking bench for weakbus_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
module tb_weakbus_arbiter;

    localparam int NM = 3;
`ifdef WEAKBUS_ARB_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NM-1:0]   m_req;
    logic [32*NM-1:0] m_addr;
    logic [32*NM-1:0] m_out;
    logic [NM-1:0]   m_wr;
    logic [4*NM-1:0] m_wr_mask;
    logic [31:0]     m_in;
    logic [NM-1:0]   m_ack;
    logic            s_req;
    logic [31:0]     s_addr;
    logic [31:0]     s_out;
    logic            s_wr;
    logic [3:0]      s_wr_mask;
    logic [31:0]     s_in;
    logic            s_ack;
    logic [NM-1:0]   grant;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    weakbus_arbiter #(.NMASTERS(NM), .TMO_W(TMO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_out(m_out),
        .m_wr(m_wr), .m_wr_mask(m_wr_mask), .m_in(m_in), .m_ack(m_ack),
        .s_req(s_req), .s_addr(s_addr), .s_out(s_out), .s_wr(s_wr),
        .s_wr_mask(s_wr_mask), .s_in(s_in), .s_ack(s_ack), .grant(grant), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        m_req = '0; m_addr = '0; m_out = '0; m_wr = '0; m_wr_mask = '0;
        s_in = '0; s_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        m_req = '1; s_ack = 1'b1; m_wr = '1; m_addr = '1;
        @(negedge clk);
        n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL reset_sreq: got %b want 0", s_req); end
        n_tests++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL reset_mack: got %b want 000", m_ack); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++; if (s_addr !== 32'h0 || s_wr !== 1'b0) begin n_fail++; $display("FAIL reset_sbus: addr %h wr %b want 0", s_addr, s_wr); end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single();
        next_cycle();
        m_req = 3'b001; m_addr[31:0] = 32'h100;
        @(negedge clk);
        n_tests++; if (grant !== 3'b000 || s_req !== 1'b0) begin n_fail++; $display("FAIL single_idle: grant %b sreq %b want 000/0", grant, s_req); end
        n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL single_idle_addr: got %h want 0", s_addr); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b001 || s_req !== 1'b1) begin n_fail++; $display("FAIL single_grant: grant %b sreq %b want 001/1", grant, s_req); end
        n_tests++; if (s_addr !== 32'h100 || m_ack !== 3'b000) begin n_fail++; $display("FAIL single_busy: addr %h ack %b want 100/000", s_addr, m_ack); end
        next_cycle();
        s_ack = 1'b1; s_in = 32'h1234_5678;
        @(negedge clk);
        n_tests++; if (m_ack !== 3'b001) begin n_fail++; $display("FAIL single_ack: got %b want 001", m_ack); end
        n_tests++; if (m_in !== 32'h1234_5678) begin n_fail++; $display("FAIL single_min: got %h want 12345678", m_in); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_tests++; if (grant !== 3'b000 || m_ack !== 3'b000) begin n_fail++; $display("FAIL single_release: grant %b ack %b want 000/000", grant, m_ack); end
    endtask

    task automatic test_alternate();
        logic [NM-1:0] exp;
        next_cycle();
        m_req = 3'b011; s_ack = 1'b1;
        m_addr[31:0] = 32'hA0; m_addr[63:32] = 32'hB0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = (c % 2 == 0) ? 3'b000 : (((c / 2) % 2 == 0) ? 3'b010 : 3'b001);
            n_tests++; if (grant !== exp) begin n_fail++; $display("FAIL alt_grant[%0d]: got %b want %b", c, grant, exp); end
            n_tests++; if (m_ack !== exp) begin n_fail++; $display("FAIL alt_ack[%0d]: got %b want %b", c, m_ack, exp); end
            if (c % 2 == 1) begin
                n_tests++;
                if (s_addr !== (exp == 3'b010 ? 32'hB0 : 32'hA0)) begin n_fail++; $display("FAIL alt_addr[%0d]: got %h", c, s_addr); end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_write_gating();
        next_cycle();
        m_req = 3'b010; m_wr = 3'b011;
        m_out[31:0] = 32'h1111_1111; m_wr_mask[3:0] = 4'b0011;
        m_out[63:32] = 32'hAABB_0000; m_wr_mask[7:4] = 4'b1100;
        @(negedge clk);
        n_tests++; if (s_wr !== 1'b0 || s_wr_mask !== 4'b0000 || s_out !== 32'h0) begin n_fail++; $display("FAIL wr_idle: wr %b mask %b out %h want zeros", s_wr, s_wr_mask, s_out); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (s_wr !== 1'b1 || s_wr_mask !== 4'b1100) begin n_fail++; $display("FAIL wr_busy: wr %b mask %b want 1/1100", s_wr, s_wr_mask); end
        n_tests++; if (s_out !== 32'hAABB_0000) begin n_fail++; $display("FAIL wr_data: got %h want aabb0000", s_out); end
        next_cycle();
        s_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (m_ack !== 3'b010) begin n_fail++; $display("FAIL wr_ack: got %b want 010", m_ack); end
        next_cycle();
        s_ack = 1'b0; m_req = '0;
        @(negedge clk);
        n_tests++; if (s_wr !== 1'b0 || s_wr_mask !== 4'b0000 || s_out !== 32'h0) begin n_fail++; $display("FAIL wr_after: wr %b mask %b out %h want zeros", s_wr, s_wr_mask, s_out); end
        clear_inputs();
    endtask

    task automatic test_abort();
        next_cycle();
        m_req = 3'b001;
        next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b001) begin n_fail++; $display("FAIL abort_grant: got %b want 001", grant); end
        next_cycle();
        m_req = 3'b000;
        @(negedge clk);
        n_tests++; if (s_req !== 1'b0 || m_ack !== 3'b000) begin n_fail++; $display("FAIL abort_noack: sreq %b ack %b want 0/000", s_req, m_ack); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL abort_idle: got %b want 000", grant); end
        next_cycle();
        m_req = 3'b111;
        next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b100) begin n_fail++; $display("FAIL abort_next: got %b want 100", grant); end
        next_cycle();
        s_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (m_ack !== 3'b100) begin n_fail++; $display("FAIL abort_ack: got %b want 100", m_ack); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        next_cycle();
        m_req = 3'b010;
        next_cycle();
        s_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (m_ack !== 3'b010 || s_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre: ack %b sreq %b want 010/1", m_ack, s_req); end
        #1 rst = 1'b0;
        #1;
        n_tests++; if (grant !== 3'b000 || s_req !== 1'b0 || m_ack !== 3'b000) begin n_fail++; $display("FAIL areset_now: grant %b sreq %b ack %b want 0", grant, s_req, m_ack); end
        next_cycle();
        rst = 1'b1; s_ack = 1'b0; m_req = 3'b111;
        next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b001) begin n_fail++; $display("FAIL areset_prio: got %b want 001", grant); end
        next_cycle();
        s_ack = 1'b1;
        next_cycle();
        clear_inputs();
    endtask

`ifdef WEAKBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NM-1:0] exp;
        next_cycle();
        m_req = 3'b001; s_in = 32'h0;
        @(negedge clk);
        for (int b = 1; b <= 16; b++) begin
            next_cycle();
            @(negedge clk);
            exp = (b == 16) ? 3'b001 : 3'b000;
            n_tests++; if (m_ack !== exp) begin n_fail++; $display("FAIL tmo_ack[%0d]: got %b want %b", b, m_ack, exp); end
        end
        n_tests++; if (m_in !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tmo_poison: got %h want deadbeef", m_in); end
        next_cycle();
        m_req = '0;
        @(negedge clk);
        n_tests++; if (err !== 1'b1 || grant !== 3'b000) begin n_fail++; $display("FAIL tmo_err: err %b grant %b want 1/000", err, grant); end
        repeat (3) next_cycle();
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err); end
        clear_inputs();
    endtask
`else
    task automatic test_timeout();
        next_cycle();
        m_req = 3'b001;
        repeat (40) next_cycle();
        @(negedge clk);
        n_tests++; if (grant !== 3'b001 || m_ack !== 3'b000) begin n_fail++; $display("FAIL notmo_wait: grant %b ack %b want 001/000", grant, m_ack); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL notmo_err: got %b want 0", err); end
        next_cycle();
        s_ack = 1'b1;
        next_cycle();
        clear_inputs();
    endtask
`endif

    task automatic test_random();
        int owner = -1;
        int last  = NM - 1;
        int wait_cnt = 0;
        bit merr = 1'b0;
        bit fire;
        logic [NM-1:0] eg;
        logic [NM-1:0] ea;
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        rst = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            next_cycle();
            for (int i = 0; i < NM; i++) begin
                if (m_req[i]) m_req[i] = ($urandom_range(0, 9) != 0);
                else          m_req[i] = ($urandom_range(0, 9) < 4);
                m_addr[i*32 +: 32]  = $urandom;
                m_out[i*32 +: 32]   = $urandom;
                m_wr[i]             = 1'($urandom_range(0, 1));
                m_wr_mask[i*4 +: 4] = 4'($urandom);
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_in  = $urandom;
            @(negedge clk);
            eg = '0;
            if (owner >= 0) eg[owner] = 1'b1;
            fire = TMO_EN && owner >= 0 && wait_cnt == (2**TMO - 1) && !s_ack && m_req[owner];
            ea = (owner >= 0 && (s_ack || fire)) ? eg : '0;
            n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, eg); end
            n_tests++; if (m_ack !== ea) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, m_ack, ea); end
            n_tests++; if (s_req !== (owner >= 0 && m_req[owner])) begin n_fail++; $display("FAIL rnd_sreq@%0d: got %b", cyc, s_req); end
            n_tests++; if (err !== merr) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err, merr); end
            if (owner >= 0) begin
                n_tests++; if (s_addr !== m_addr[owner*32 +: 32]) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, s_addr, m_addr[owner*32 +: 32]); end
                n_tests++; if (s_out !== m_out[owner*32 +: 32]) begin n_fail++; $display("FAIL rnd_out@%0d: got %h want %h", cyc, s_out, m_out[owner*32 +: 32]); end
                n_tests++; if (s_wr !== m_wr[owner] || s_wr_mask !== m_wr_mask[owner*4 +: 4]) begin n_fail++; $display("FAIL rnd_wr@%0d: wr %b mask %b", cyc, s_wr, s_wr_mask); end
                n_tests++; if (m_in !== (fire ? 32'hDEADBEEF : s_in)) begin n_fail++; $display("FAIL rnd_min@%0d: got %h", cyc, m_in); end
            end else begin
                n_tests++; if (s_addr !== 32'h0 || s_out !== 32'h0 || s_wr !== 1'b0 || s_wr_mask !== 4'h0) begin n_fail++; $display("FAIL rnd_idle@%0d: addr %h out %h wr %b mask %b", cyc, s_addr, s_out, s_wr, s_wr_mask); end
            end
            if (owner < 0) begin
                wait_cnt = 0;
                for (int k = 1; k <= NM; k++) begin
                    if (m_req[(last + k) % NM]) begin
                        owner = (last + k) % NM;
                        break;
                    end
                end
            end else if (s_ack || fire) begin
                if (fire) merr = 1'b1;
                last  = owner;
                owner = -1;
            end else if (!m_req[owner]) begin
                owner = -1;
            end else begin
                wait_cnt++;
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_write_gating();
        test_abort();
        test_async_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
